// File: rtl/if_id_stage.sv
// if_id_stage: instruction-fetch back end and IF/ID pipeline register.
// It issues the current PC to a synchronous instruction memory with a
// one-cycle read latency. It then pairs the returned word with its PC for
// decode. A stall parks the in-flight word in a one-entry hold buffer, and a
// flush squashes everything in flight.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | imem_data_i is live for req_pc_q and feeds the ID register
//   HOLD  | hold buffer owns the word for req_pc_q; imem_data_i is ignored
module if_id_stage #(
   parameter int                ADDR_W = 32,
   parameter int                INSN_W = 32,
   parameter logic [INSN_W-1:0] NOP    = 32'h00000013
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [INSN_W-1:0] imem_data_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic              imem_re_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc_plus4_o,
   output logic [INSN_W-1:0] insn_o,
   output logic              valid_o
);

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              req_valid_q, req_valid_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              hold_valid_q, hold_valid_d;
   logic [INSN_W-1:0] hold_insn_q, hold_insn_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INSN_W-1:0] insn_q, insn_d;
   logic              valid_q, valid_d;

   // Memory interface: the address passes straight through, and the read is
   // gated whenever the request could not be accepted next cycle.
   always_comb begin
      imem_addr_o = pc_i;
      imem_re_o   = start_i & ~stall_i & ~flush_i & ~rst_i;
   end

   // Request stage: tracks which PC the memory is currently answering for.
   always_comb begin
      req_valid_d = req_valid_q;
      req_pc_d    = req_pc_q;
      if (flush_i) begin
         req_valid_d = 1'b0;
      end else if (!stall_i) begin
         req_valid_d = imem_re_o;
         req_pc_d    = pc_i;
      end
   end

   // Hold-buffer FSM: capture the returning word when a stall would drop it.
   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_insn_d  = hold_insn_q;
      case (state_q)
         RUN: begin
            if (stall_i && !flush_i && req_valid_q) begin
               hold_insn_d  = imem_data_i;
               hold_valid_d = 1'b1;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (flush_i || !stall_i) begin
               hold_valid_d = 1'b0;
               state_d      = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // ID register: flush squashes, stall freezes, otherwise take the word
   // from the hold buffer or the memory, or insert a bubble.
   always_comb begin
      pc_d    = pc_q;
      insn_d  = insn_q;
      valid_d = valid_q;
      if (flush_i) begin
         valid_d = 1'b0;
         insn_d  = NOP;
      end else if (stall_i) begin
         valid_d = valid_q;
      end else if (state_q == HOLD) begin
         pc_d    = req_pc_q;
         insn_d  = hold_insn_q;
         valid_d = 1'b1;
      end else if (req_valid_q) begin
         pc_d    = req_pc_q;
         insn_d  = imem_data_i;
         valid_d = 1'b1;
      end else begin
         valid_d = 1'b0;
         insn_d  = NOP;
      end
   end

   // State registers with synchronous reset that overrides every input.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= RUN;
         req_valid_q  <= 1'b0;
         req_pc_q     <= '0;
         hold_valid_q <= 1'b0;
         hold_insn_q  <= NOP;
         pc_q         <= '0;
         insn_q       <= NOP;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_valid_q  <= req_valid_d;
         req_pc_q     <= req_pc_d;
         hold_valid_q <= hold_valid_d;
         hold_insn_q  <= hold_insn_d;
         pc_q         <= pc_d;
         insn_q       <= insn_d;
         valid_q      <= valid_d;
      end
   end

   // pc_plus4_o is derived from pc_o and wraps naturally at 2^ADDR_W.
   always_comb begin
      pc_o       = pc_q;
      pc_plus4_o = pc_q + ADDR_W'(4);
      insn_o     = insn_q;
      valid_o    = valid_q;
   end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch back end and IF/ID pipeline register. Sits directly downstream of the PC register.
- Takes the current PC each cycle and issues it to the synchronous instruction memory, which has a fixed 1-cycle read latency.
- Pairs the returned instruction word with its PC and presents the pair to decode.
- Handles hazard-unit stalls with a one-entry hold buffer, and branch flushes by squashing.

Parameters:
- ADDR_W, 32, PC/address width
- INSN_W, 32, instruction width
- NOP, 32'h00000013, bubble instruction driven on insn_o when no valid instruction is held

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- start_i  input  1  CPU run enable; no fetch requests issued while low
- stall_i  input  1  hazard stall; holds the request stage and the ID register
- flush_i  input  1  branch/jump taken; squash all in-flight fetches
- pc_i  input  ADDR_W  current PC from the PC register
- imem_data_i  input  INSN_W  instruction memory read data, for the address requested in the previous cycle
- imem_addr_o  output  ADDR_W  instruction memory address, combinational copy of pc_i
- imem_re_o  output  1  instruction memory read enable
- pc_o  output  ADDR_W  PC of the instruction in ID
- pc_plus4_o  output  ADDR_W  pc_o + 4, modulo 2^ADDR_W
- insn_o  output  INSN_W  instruction in ID
- valid_o  output  1  ID holds a real (non-bubble) instruction

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - req_valid=0, req_pc=0, hold_valid=0, state=RUN.
  - pc_o=0, pc_plus4_o=4, insn_o=NOP, valid_o=0.
  - Reset overrides every other input, including mid-stall and mid-HOLD.
- Combinational:
  - imem_addr_o = pc_i.
  - imem_re_o = start_i & ~stall_i & ~flush_i & ~rst_i.
- Request stage, updated each edge unless reset:
  - flush_i=1: req_valid<=0.
  - else stall_i=1: req_valid and req_pc hold.
  - else: req_valid<=imem_re_o, req_pc<=pc_i.
- State machine:
  - RUN: imem_data_i is live for req_pc.
    - stall_i & ~flush_i & req_valid: capture hold_insn<=imem_data_i, hold_valid<=1, go to HOLD.
    - Otherwise stay in RUN.
  - HOLD: buffered word is authoritative; imem_data_i is ignored.
    - flush_i: hold_valid<=0, go to RUN.
    - ~stall_i: the ID register loads from the hold buffer, hold_valid<=0, go to RUN.
    - stall_i: stay in HOLD.
- ID register, priority top to bottom:
  - flush_i: valid_o<=0, insn_o<=NOP, pc_o holds.
  - stall_i: all outputs hold.
  - state=HOLD: load {req_pc, hold_insn}, valid_o<=1.
  - req_valid: load {req_pc, imem_data_i}, valid_o<=1.
  - else: bubble, with valid_o<=0, insn_o<=NOP, pc_o holding.
- pc_plus4_o is registered alongside pc_o, or derived combinationally from pc_o; either way it is always pc_o+4, and wraps at 2^ADDR_W (0xFFFFFFFC -> 0).
- Latency: PC presented in cycle t reaches the ID outputs after the edge ending cycle t+1, i.e. visible in t+2.
- Throughput: one instruction per cycle with no stall or flush.
- Simultaneous events:
  - flush beats stall.
  - A stall rising in the same cycle that a flush clears HOLD leaves state RUN, because the flush also cleared req_valid.
- start_i falling: no new requests. An in-flight request still completes into ID. The pipeline then drains to bubbles.

Test Plan:
- Reset then straight-line fetch: hold rst_i=1 for 2 cycles, then start_i=1 with pc_i=0,4,8 and the memory returning 0xA0,0xA4,0xA8 -> cycle 2 after reset release shows pc_o=0, insn_o=0xA0, valid_o=1, pc_plus4_o=4; then 4/0xA4 and 8/0xA8 on consecutive cycles.
- Stall with hold: while the request for pc 0x10 is outstanding, assert stall_i for 3 cycles and change imem_data_i to garbage after the first -> state HOLD, imem_re_o=0, ID outputs frozen; after release, ID shows pc 0x10 with the originally returned word and valid_o=1.
- Flush: assert flush_i one cycle while fetches of 0x20 and 0x24 are in flight -> next cycle valid_o=0, insn_o=NOP; neither 0x20 nor 0x24 ever appears in ID; the target fetched afterwards appears 2 cycles after it is presented.
- Flush+stall same cycle while in HOLD -> flush wins: valid_o=0, hold_valid=0, state=RUN.
- Reset mid-HOLD: assert rst_i while in HOLD -> next edge gives valid_o=0, insn_o=NOP, pc_o=0, state=RUN; the stale buffered word never appears.
- Wrap and start gating: pc_i=0xFFFFFFFC -> pc_plus4_o=0. Drop start_i -> imem_re_o=0 immediately; one final valid instruction, then valid_o=0.
